// File: rtl/ferry_ctrl_if.sv
// Ride-request / cargo-select bundle between the
// requesting side (master) and the ferry controller (slave).
interface ferry_ctrl_if;
    logic req_w;
    logic req_g;
    logic req_c;
    logic sel_w;
    logic sel_g;
    logic sel_c;
    logic trip_stb;

    modport master (
        output req_w, req_g, req_c,
        input  sel_w, sel_g, sel_c, trip_stb
    );

    modport slave (
        input  req_w, req_g, req_c,
        output sel_w, sel_g, sel_c, trip_stb
    );
endinterface

// File: rtl/ferry_ctrl.sv
// Wolf/goat/cabbage crossing sequencer: safe-move
// round-robin arbitration and multi-cycle crossings.
module ferry_ctrl #(
    parameter int TRIP_W       = 4,
    parameter int CROSS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    ferry_ctrl_if.slave       bus,
    output logic              bank_m,
    output logic              bank_w,
    output logic              bank_g,
    output logic              bank_c,
    output logic [TRIP_W-1:0] trip_cnt,
    output logic              busy,
    output logic              blocked,
    output logic              done,
    output logic              fail
);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        CROSS,
        DONE
    } state_t;

    localparam int CW =
        (CROSS_CYCLES > 1) ? $clog2(CROSS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CROSS_CYCLES - 1);

    state_t      state;
    logic [CW-1:0] cyc;
    logic [1:0]  ptr;
    logic [1:0]  nxt_ptr;
    logic [2:0]  req;
    logic [2:0]  here;
    logic [2:0]  elig;
    logic [2:0]  gnt;
    logic        safe0;
    logic        nb_w;
    logic        nb_g;
    logic        nb_c;
    logic        all_far;
    logic [TRIP_W-1:0] cnt_n;

    // Caller guarantees the man is leaving this bank.
    function automatic logic unsafe(input logic [2:0] h);
        return (h[0] & h[1]) | (h[1] & h[2]);
    endfunction

    assign req  = {bus.req_c, bus.req_g, bus.req_w};
    assign here = {bank_c == bank_m,
                   bank_g == bank_m,
                   bank_w == bank_m};

    assign elig[0] = req[0] & here[0]
                   & ~unsafe(here & 3'b110);
    assign elig[1] = req[1] & here[1]
                   & ~unsafe(here & 3'b101);
    assign elig[2] = req[2] & here[2]
                   & ~unsafe(here & 3'b011);
    assign safe0   = ~unsafe(here);

    always_comb begin
        gnt = 3'b000;
        case (ptr)
            2'd0: begin
                if (elig[0])      gnt = 3'b001;
                else if (elig[1]) gnt = 3'b010;
                else if (elig[2]) gnt = 3'b100;
            end
            2'd1: begin
                if (elig[1])      gnt = 3'b010;
                else if (elig[2]) gnt = 3'b100;
                else if (elig[0]) gnt = 3'b001;
            end
            2'd2: begin
                if (elig[2])      gnt = 3'b100;
                else if (elig[0]) gnt = 3'b001;
                else if (elig[1]) gnt = 3'b010;
            end
            default: gnt = 3'b000;
        endcase
    end

    always_comb begin
        nxt_ptr = ptr;
        if (gnt[0]) nxt_ptr = 2'd1;
        if (gnt[1]) nxt_ptr = 2'd2;
        if (gnt[2]) nxt_ptr = 2'd0;
    end

    assign blocked = (state == ARB) & ~(|elig) & ~safe0;

    assign nb_w    = bank_w ^ bus.sel_w;
    assign nb_g    = bank_g ^ bus.sel_g;
    assign nb_c    = bank_c ^ bus.sel_c;
    assign all_far = ~bank_m & nb_w & nb_g & nb_c;
    assign cnt_n   = trip_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cyc          <= '0;
            ptr          <= 2'd0;
            bank_m       <= 1'b0;
            bank_w       <= 1'b0;
            bank_g       <= 1'b0;
            bank_c       <= 1'b0;
            trip_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            bus.sel_w    <= 1'b0;
            bus.sel_g    <= 1'b0;
            bus.sel_c    <= 1'b0;
            bus.trip_stb <= 1'b0;
        end else begin
            bus.trip_stb <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= ARB;
                        ptr      <= 2'd0;
                        bank_m   <= 1'b0;
                        bank_w   <= 1'b0;
                        bank_g   <= 1'b0;
                        bank_c   <= 1'b0;
                        trip_cnt <= '0;
                        done     <= 1'b0;
                        fail     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ARB: begin
                    if ((|elig) | safe0) begin
                        state <= CROSS;
                        cyc   <= '0;
                        ptr   <= nxt_ptr;
                        {bus.sel_c, bus.sel_g, bus.sel_w} <= gnt;
                        bus.trip_stb <= (CROSS_CYCLES == 1);
                    end
                end
                CROSS: begin
                    if (cyc == LAST) begin
                        bank_m    <= ~bank_m;
                        bank_w    <= nb_w;
                        bank_g    <= nb_g;
                        bank_c    <= nb_c;
                        trip_cnt  <= cnt_n;
                        bus.sel_w <= 1'b0;
                        bus.sel_g <= 1'b0;
                        bus.sel_c <= 1'b0;
                        // Completion outranks the trip limit.
                        if (all_far) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (&cnt_n) begin
                            state <= DONE;
                            fail  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= ARB;
                        end
                    end else begin
                        cyc          <= cyc + 1'b1;
                        bus.trip_stb <= (cyc + 1'b1 == LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ferry_ctrl.md
# ferry_ctrl

Sequencing controller for the wolf/goat/cabbage river-crossing datapath. Holds the bank state of man, wolf, goat and cabbage. Arbitrates round-robin among passenger ride requests, granting only moves that leave no unsafe bank behind. Drives one-hot cargo selects (`sel_w`/`sel_g`/`sel_c`, same meaning as the datapath's `w`/`g`/`c` inputs) for a multi-cycle crossing, and reports completion, stall and trip-limit failure.

## Interface
- `TRIP_W`, default 4: width of trip counter; trip limit = 2^TRIP_W − 1.
- `CROSS_CYCLES`, default 2: cycles a crossing occupies; legal range ≥ 1.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `req_w`, `req_g`, `req_c`  in  1 each  ride requests, sampled in ARB only.
- `sel_w`, `sel_g`, `sel_c`  out  1 each  cargo of current crossing; zero-or-one-hot, held for all of CROSS.
- `trip_stb`  out  1  one-cycle pulse on the last CROSS cycle.
- `bank_m`, `bank_w`, `bank_g`, `bank_c`  out  1 each  0 = near bank, 1 = far bank.
- `trip_cnt`  out  TRIP_W  completed crossings this run.
- `busy`  out  1  high in ARB or CROSS.
- `blocked`  out  1  high in an ARB cycle where no legal move exists.
- `done`  out  1  all on far bank; held in DONE.
- `fail`  out  1  trip limit reached without done; held in DONE.

## Operation
- States: IDLE, ARB, CROSS, DONE.
- Reset: state IDLE; all banks 0; `trip_cnt` 0; RR pointer at w; all outputs 0.
- IDLE/DONE + `start`: clear banks, `trip_cnt`, `done` and `fail`; pointer to w; go to ARB.
- ARB, legality:
  - Passenger x is eligible iff `req_x`, `bank_x == bank_m`, and the bank being left is safe after x departs.
  - A bank is unsafe iff the man is absent and it holds (wolf & goat) or (goat & cabbage).
- ARB, grant:
  - Grant the first eligible passenger in circular order w→g→c, starting at the pointer.
  - If none is eligible, the man crosses alone when that is safe.
  - If nothing is legal, assert `blocked`, stay in ARB and re-evaluate next cycle.
- On grant: latch the select and go to CROSS. The pointer moves to the entry after the granted passenger; an empty trip leaves it unchanged.
- CROSS: hold the select for `CROSS_CYCLES` cycles; `trip_stb` pulses in the final cycle.
- End of crossing, at the clock edge closing the final CROSS cycle:
  - Toggle `bank_m` and the bank of the selected passenger.
  - Increment `trip_cnt`.
  - Next state is DONE with `done`=1 if all four banks are 1.
  - Else next state is DONE with `fail`=1 if `trip_cnt` reaches 2^TRIP_W−1.
  - Else next state is ARB.
- If completion and limit coincide, `done` wins and `fail` stays 0.
- Selects are 0 outside CROSS.
- `start` is ignored while `busy`.
- `rst_n` low in any state, including mid-CROSS, returns to reset values at the next edge; a partial crossing has no effect.

## Timing
- `start` accepted at edge k: ARB during cycle k+1.
- Grant at the end of ARB: CROSS occupies cycles k+2 .. k+1+CROSS_CYCLES.
- New banks and `trip_cnt` are visible the cycle after `trip_stb`.
- Trip period without blocking: 1 + CROSS_CYCLES cycles.
- `done`/`fail` assert the cycle after the final `trip_stb`.
- `blocked` is combinational from ARB state and the `req_*` inputs.
- All other outputs are registered.

## Test plan
- Canonical solution, CROSS_CYCLES=2:
  - Stimulus: one-hot requests per ARB, in order g, none, w, g, c, none, g.
  - Required: 7 `trip_stb` pulses 3 cycles apart; `done`=1 and `trip_cnt`=7 the cycle after the 7th pulse.
  - Required: banks {m,w,g,c}=1111; `fail`=0.
- Unsafe request at start:
  - Stimulus: `req_w` only.
  - Required: `blocked`=1, no CROSS, banks stay 0000.
  - Then raise `req_g`: g is granted the next ARB cycle.
- Round-robin:
  - Stimulus: after trips g and empty (pointer at c, m/w/c near, g far), assert `req_w` and `req_c`.
  - Required: `sel_c`=1 is granted; the next near-bank tie then grants w.
- Trip limit, TRIP_W=2:
  - Stimulus: alternate g, g requests.
  - Required: after the 3rd `trip_stb`, `fail`=1, `done`=0, state DONE.
  - Then `start`: banks clear and `trip_cnt`=0.
- Reset mid-CROSS:
  - Stimulus: `rst_n`=0 for one cycle during the first CROSS cycle of the goat trip.
  - Required: next cycle all outputs 0 and IDLE; no `trip_stb`; banks 0000.
- Busy start:
  - Stimulus: `start` pulsed during CROSS.
  - Required: no effect on `trip_cnt`, banks or state sequence.
